ngp_core_mc: RTL and testbench

Parametrised multi-cycle successor of the nandgame-plus core. It has configurable data width, program-address width and data-memory depth. Instruction fetch uses a request/valid handshake, so wait-state memories are tolerated. The core also supports halt/resume. It sits between the instruction ROM/bus and the rest of the SoC, and owns four registers and a private data RAM.

---
 rtl/ngp_pkg.sv | 55 +++++
 rtl/ngp_alu.sv | 57 +++++
 rtl/ngp_core_mc.sv | 138 +++++++++++++
 tb/tb_ngp_core_mc.sv | 316 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ngp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ngp_pkg : shared types and instruction field positions for       |
// |           ngp_core_mc.   Revision: 1.0                           |
// +------------------------------------------------------------------+
package ngp_pkg;

  typedef enum logic [1:0] {
    ST_FETCH  = 2'd0,
    ST_EXEC   = 2'd1,
    ST_HALTED = 2'd2
  } ngp_state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_XOR   = 3'd4,
    ALU_NOTX  = 3'd5,
    ALU_PASSY = 3'd6,
    ALU_INCX  = 3'd7
  } ngp_alu_op_t;

  typedef enum logic [2:0] {
    JC_NEVER  = 3'd0,
    JC_GT     = 3'd1,
    JC_EQ     = 3'd2,
    JC_GE     = 3'd3,
    JC_LT     = 3'd4,
    JC_NE     = 3'd5,
    JC_LE     = 3'd6,
    JC_ALWAYS = 3'd7
  } ngp_jcond_t;

  localparam int IR_LDI    = 15;
  localparam int IR_IMM_HI = 14;
  localparam int IR_OP_HI  = 14;
  localparam int IR_OP_LO  = 12;
  localparam int IR_YSEL   = 11;
  localparam int IR_DST_HI = 10;
  localparam int IR_DST_LO = 9;
  localparam int IR_X_HI   = 8;
  localparam int IR_X_LO   = 7;
  localparam int IR_Y_HI   = 6;
  localparam int IR_Y_LO   = 5;
  localparam int IR_WMEM   = 4;
  localparam int IR_HALT   = 3;
  localparam int IR_JC_HI  = 2;
  localparam int IR_JC_LO  = 0;

  localparam int T_IDX = 3;

endpackage
`default_nettype wire

// File: rtl/ngp_alu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ngp_alu : combinational ALU and signed jump-condition evaluation. |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ngp_alu
  import ngp_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  ngp_alu_op_t       i_op,
  input  logic [DATA_W-1:0] i_x,
  input  logic [DATA_W-1:0] i_y,
  input  ngp_jcond_t        i_jcond,
  output logic [DATA_W-1:0] o_result,
  output logic              o_jump_taken
);

  logic w_neg;
  logic w_zero;

  always_comb begin
    o_result = '0;
    case (i_op)
      ALU_ADD:   o_result = i_x + i_y;
      ALU_SUB:   o_result = i_x - i_y;
      ALU_AND:   o_result = i_x & i_y;
      ALU_OR:    o_result = i_x | i_y;
      ALU_XOR:   o_result = i_x ^ i_y;
      ALU_NOTX:  o_result = ~i_x;
      ALU_PASSY: o_result = i_y;
      ALU_INCX:  o_result = i_x + DATA_W'(1);
      default:   o_result = '0;
    endcase
  end

  // Conditions treat the result as a signed two's-complement value.
  assign w_neg  = o_result[DATA_W-1];
  assign w_zero = (o_result == '0);

  always_comb begin
    o_jump_taken = 1'b0;
    case (i_jcond)
      JC_NEVER:  o_jump_taken = 1'b0;
      JC_GT:     o_jump_taken = !w_neg && !w_zero;
      JC_EQ:     o_jump_taken = w_zero;
      JC_GE:     o_jump_taken = !w_neg;
      JC_LT:     o_jump_taken = w_neg;
      JC_NE:     o_jump_taken = !w_zero;
      JC_LE:     o_jump_taken = w_neg || w_zero;
      JC_ALWAYS: o_jump_taken = 1'b1;
      default:   o_jump_taken = 1'b0;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ngp_core_mc.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ngp_core_mc : multi-cycle nandgame-plus core with handshaked     |
// | fetch and halt/resume. NGP_CORE_DBG_EN adds retire outputs.      |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ngp_core_mc
  import ngp_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int ADDR_W     = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic              clk,
  input  logic              _rst,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_valid,
  input  logic [15:0]       imem_instr,
  input  logic              resume,
  output logic              halted
`ifdef NGP_CORE_DBG_EN
  ,
  output logic              retire_valid,
  output logic [ADDR_W-1:0] retire_pc,
  output logic [DATA_W-1:0] retire_result
`endif
);

  localparam int MEM_AW = $clog2(DMEM_DEPTH);

  ngp_state_t        r_state;
  ngp_state_t        w_state_nxt;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_nxt;
  logic [15:0]       r_ir;
  logic [DATA_W-1:0] r_regs [4];
  logic [DATA_W-1:0] r_mem  [DMEM_DEPTH];

  logic [DATA_W-1:0] w_t;
  logic [MEM_AW-1:0] w_maddr;
  logic [DATA_W-1:0] w_x;
  logic [DATA_W-1:0] w_y;
  logic [DATA_W-1:0] w_alu_res;
  logic [DATA_W-1:0] w_wdata;
  logic [1:0]        w_dst;
  logic              w_jump;
  logic              w_is_ldi;
  logic              w_exec;
  logic              w_mem_we;

  assign w_t      = r_regs[T_IDX];
  assign w_maddr  = w_t[MEM_AW-1:0];
  assign w_is_ldi = r_ir[IR_LDI];
  assign w_exec   = (r_state == ST_EXEC);
  assign w_x      = r_regs[r_ir[IR_X_HI:IR_X_LO]];
  assign w_y      = r_ir[IR_YSEL] ? r_mem[w_maddr] : r_regs[r_ir[IR_Y_HI:IR_Y_LO]];

  ngp_alu #(.DATA_W(DATA_W)) u_alu (
    .i_op         (ngp_alu_op_t'(r_ir[IR_OP_HI:IR_OP_LO])),
    .i_x          (w_x),
    .i_y          (w_y),
    .i_jcond      (ngp_jcond_t'(r_ir[IR_JC_HI:IR_JC_LO])),
    .o_result     (w_alu_res),
    .o_jump_taken (w_jump)
  );

  assign w_wdata  = w_is_ldi ? DATA_W'(r_ir[IR_IMM_HI:0]) : w_alu_res;
  assign w_dst    = w_is_ldi ? 2'(T_IDX) : r_ir[IR_DST_HI:IR_DST_LO];
  assign w_mem_we = w_exec && !w_is_ldi && r_ir[IR_WMEM];

  // Jump target and memory address both come from T before this instruction's write.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    case (r_state)
      ST_FETCH: begin
        if (imem_valid) w_state_nxt = ST_EXEC;
      end
      ST_EXEC: begin
        w_pc_nxt    = (!w_is_ldi && w_jump) ? ADDR_W'(w_t) : r_pc + ADDR_W'(1);
        w_state_nxt = (!w_is_ldi && r_ir[IR_HALT]) ? ST_HALTED : ST_FETCH;
      end
      ST_HALTED: begin
        if (resume) w_state_nxt = ST_FETCH;
      end
      default: w_state_nxt = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_state <= ST_FETCH;
      r_pc    <= '0;
      r_ir    <= '0;
      for (int i = 0; i < 4; i++) r_regs[i] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      if (r_state == ST_FETCH && imem_valid) r_ir <= imem_instr;
      if (w_exec) r_regs[w_dst] <= w_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (w_mem_we) r_mem[w_maddr] <= w_wdata;
  end

  assign imem_req  = _rst && (r_state == ST_FETCH);
  assign imem_addr = r_pc;
  assign halted    = (r_state == ST_HALTED);

`ifdef NGP_CORE_DBG_EN
  logic              r_retire_valid;
  logic [ADDR_W-1:0] r_retire_pc;
  logic [DATA_W-1:0] r_retire_result;

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      r_retire_valid  <= 1'b0;
      r_retire_pc     <= '0;
      r_retire_result <= '0;
    end else begin
      r_retire_valid <= w_exec;
      if (w_exec) begin
        r_retire_pc     <= r_pc;
        r_retire_result <= w_wdata;
      end
    end
  end

  assign retire_valid  = r_retire_valid;
  assign retire_pc     = r_retire_pc;
  assign retire_result = r_retire_result;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ngp_core_mc.sv
`default_nettype none
// tb_ngp_core_mc: randomized stimulus for ngp_core_mc, checked every cycle
// against an instruction-level model plus directed literal expectations.
module tb_ngp_core_mc;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 16;
  localparam int DEPTH    = 256;
  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_HALT  = 2;

  logic              clk        = 1'b0;
  logic              rst_n      = 1'b0;
  logic              imem_valid = 1'b0;
  logic [15:0]       imem_instr = 16'h0;
  logic              resume     = 1'b0;
  logic              imem_req;
  logic              halted;
  logic [ADDR_W-1:0] imem_addr;
`ifdef NGP_CORE_DBG_EN
  logic              retire_valid;
  logic [ADDR_W-1:0] retire_pc;
  logic [DATA_W-1:0] retire_result;
`endif

  ngp_core_mc #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DMEM_DEPTH(DEPTH)) dut (
    .clk           (clk),
    ._rst          (rst_n),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_valid    (imem_valid),
    .imem_instr    (imem_instr),
    .resume        (resume),
    .halted        (halted)
`ifdef NGP_CORE_DBG_EN
    ,
    .retire_valid  (retire_valid),
    .retire_pc     (retire_pc),
    .retire_result (retire_result)
`endif
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  int                m_phase = PH_FETCH;
  logic [15:0]       m_ir;
  logic [ADDR_W-1:0] m_pc;
  logic [DATA_W-1:0] m_r   [4];
  logic [DATA_W-1:0] m_mem [DEPTH];
  int                m_last_wa = -1;
  bit                m_ret_v = 1'b0;
  logic [ADDR_W-1:0] m_ret_pc;
  logic [DATA_W-1:0] m_ret_res;

  logic [15:0] q[$];
  int stall_left   = 0;
  bit always_valid = 1'b1;
  bit garbage_en   = 1'b0;
  bit rand_resume  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] ldi(input int v);
    return {1'b1, v[14:0]};
  endfunction

  function automatic logic [15:0] alu(input int op, input int ysel, input int dst, input int x,
                                      input int y, input int wm, input int h, input int jc);
    return {1'b0, op[2:0], ysel[0], dst[1:0], x[1:0], y[1:0], wm[0], h[0], jc[2:0]};
  endfunction

  // Instruction-level semantics straight from the ISA description.
  task automatic model_exec();
    logic [DATA_W-1:0] x, y, res, t;
    bit take;
    t = m_r[3];
    m_ret_pc = m_pc;
    if (m_ir[15]) begin
      res    = {1'b0, m_ir[14:0]};
      m_r[3] = res;
      m_pc   = m_pc + ADDR_W'(1);
    end else begin
      x = m_r[m_ir[8:7]];
      y = m_ir[11] ? m_mem[t[7:0]] : m_r[m_ir[6:5]];
      case (m_ir[14:12])
        3'd0: res = x + y;
        3'd1: res = x - y;
        3'd2: res = x & y;
        3'd3: res = x | y;
        3'd4: res = x ^ y;
        3'd5: res = ~x;
        3'd6: res = y;
        default: res = x + DATA_W'(1);
      endcase
      case (m_ir[2:0])
        3'd0: take = 1'b0;
        3'd1: take = $signed(res) > 0;
        3'd2: take = $signed(res) == 0;
        3'd3: take = $signed(res) >= 0;
        3'd4: take = $signed(res) < 0;
        3'd5: take = $signed(res) != 0;
        3'd6: take = $signed(res) <= 0;
        default: take = 1'b1;
      endcase
      if (m_ir[4]) begin
        m_mem[t[7:0]] = res;
        m_last_wa = int'(t[7:0]);
      end
      m_r[m_ir[10:9]] = res;
      m_pc = take ? t : m_pc + ADDR_W'(1);
    end
    m_ret_res = res;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = PH_FETCH;
      m_pc    = '0;
      m_ir    = '0;
      m_ret_v = 1'b0;
      for (int i = 0; i < 4; i++) m_r[i] = '0;
    end else begin
      m_ret_v = 1'b0;
      case (m_phase)
        PH_FETCH: if (imem_valid) begin
          if (q.size() > 0) m_ir = q.pop_front();
          m_phase = PH_EXEC;
        end
        PH_EXEC: begin
          model_exec();
          m_ret_v = 1'b1;
          m_phase = (!m_ir[15] && m_ir[3]) ? PH_HALT : PH_FETCH;
        end
        default: if (resume) m_phase = PH_FETCH;
      endcase
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_phase == PH_FETCH) begin
      if (q.size() > 0 && stall_left > 0) begin
        imem_valid = 1'b0;
        stall_left--;
      end else if (q.size() > 0 && (always_valid || $urandom_range(3, 0) != 0)) begin
        imem_valid = 1'b1;
        imem_instr = q[0];
      end else begin
        imem_valid = 1'b0;
      end
    end else begin
      imem_valid = garbage_en && ($urandom_range(1, 0) == 1);
      imem_instr = 16'($urandom);
    end
    if (rand_resume) resume = ($urandom_range(2, 0) == 0);
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("imem_req", {31'b0, imem_req}, {31'b0, m_phase == PH_FETCH});
      check("halted", {31'b0, halted}, {31'b0, m_phase == PH_HALT});
      if (m_phase == PH_FETCH) check("imem_addr", 32'(imem_addr), 32'(m_pc));
      for (int i = 0; i < 4; i++)
        check($sformatf("reg r%0d", i), 32'(dut.r_regs[i]), 32'(m_r[i]));
      if (m_last_wa >= 0)
        check("dmem", 32'(dut.r_mem[m_last_wa]), 32'(m_mem[m_last_wa]));
`ifdef NGP_CORE_DBG_EN
      check("retire_valid", {31'b0, retire_valid}, {31'b0, m_ret_v});
      if (m_ret_v) begin
        check("retire_pc", 32'(retire_pc), 32'(m_ret_pc));
        check("retire_result", 32'(retire_result), 32'(m_ret_res));
      end
`endif
    end
  end

  task automatic wait_idle(input int budget, input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!(q.size() == 0 && m_phase == PH_FETCH) && k < budget);
    check({"idle ", tag}, {31'b0, q.size() == 0 && m_phase == PH_FETCH}, 32'd1);
  endtask

  initial begin
    int cnt;
    logic [ADDR_W-1:0] pc0;
    logic [15:0] w;

    // Reset and first load immediate.
    q.push_back(ldi(5));
    repeat (3) @(negedge clk);
    check("req during reset", {31'b0, imem_req}, 32'd0);
    check("halted during reset", {31'b0, halted}, 32'd0);
    check("addr during reset", 32'(imem_addr), 32'd0);
    #2 rst_n = 1'b1;
    #1 check("req after reset", {31'b0, imem_req}, 32'd1);
    check("addr seq 0", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("addr held in exec", 32'(imem_addr), 32'd0);
    @(negedge clk);
    check("T after ldi 5", 32'(dut.r_regs[3]), 32'h5);
    check("addr seq 1", 32'(imem_addr), 32'd1);

    // Clear every data-RAM word so ysel reads are deterministic.
    for (int a = 0; a < DEPTH; a++) begin
      q.push_back(ldi(a));
      q.push_back(alu(6, 0, 0, 0, 0, 1, 0, 0));
    end
    wait_idle(3000, "mem init");

    // r1=0x7FFF, r2=1, r0=r1+r2 with jump on lt to T=0x40.
    q.push_back(ldi(16'h7FFF));
    q.push_back(alu(6, 0, 1, 0, 3, 0, 0, 0));
    q.push_back(ldi(1));
    q.push_back(alu(6, 0, 2, 0, 3, 0, 0, 0));
    q.push_back(ldi(16'h40));
    q.push_back(alu(0, 0, 0, 1, 2, 0, 0, 4));
    wait_idle(100, "add");
    check("add r0", 32'(dut.r_regs[0]), 32'h8000);
    check("model r0", 32'(m_r[0]), 32'h8000);
    check("lt jump pc", 32'(imem_addr), 32'h40);

    // Three fetch cycles without imem_valid stretch one instruction to 5 cycles.
    pc0 = imem_addr;
    stall_left = 2;
    q.push_back(ldi(16'h10));
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (imem_addr == pc0 && cnt < 20);
    check("stalled instr cycles", 32'(cnt), 32'd5);

    // dst=T with memory write and unconditional jump use the old T.
    q.push_back(alu(0, 0, 3, 0, 1, 1, 0, 7));
    wait_idle(100, "wmem");
    check("mem[0x10]", 32'(dut.r_mem[16]), 32'hFFFF);
    check("jump to old T", 32'(imem_addr), 32'h10);
    check("T gets result", 32'(dut.r_regs[3]), 32'hFFFF);

    // Halt at pc=7, then resume from 8.
    q.push_back(ldi(7));
    q.push_back(alu(6, 0, 0, 0, 3, 0, 0, 7));
    q.push_back(alu(0, 0, 1, 0, 0, 0, 1, 0));
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!halted && cnt < 40);
    check("halted set", {31'b0, halted}, 32'd1);
    check("req low when halted", {31'b0, imem_req}, 32'd0);
    check("halting write r1", 32'(dut.r_regs[1]), 32'd14);
    repeat (3) @(negedge clk);
    check("halt holds", {31'b0, halted}, 32'd1);
    resume = 1'b1;
    @(negedge clk);
    resume = 1'b0;
    check("req after resume", {31'b0, imem_req}, 32'd1);
    check("resume addr", 32'(imem_addr), 32'd8);

    // Randomized program with wait states, stray valids and resume pulses.
    always_valid = 1'b0;
    garbage_en   = 1'b1;
    rand_resume  = 1'b1;
    for (int n = 0; n < 400; n++) begin
      w = 16'($urandom);
      if (w[3] && $urandom_range(7, 0) != 0) w[3] = 1'b0;
      q.push_back(w);
    end
    wait_idle(20000, "random");
    rand_resume = 1'b0;
    resume = 1'b0;

    // Reset asserted in the middle of EXEC.
    for (int n = 0; n < 10; n++) begin
      w = 16'($urandom);
      w[3] = 1'b0;
      q.push_back(w);
    end
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (m_phase != PH_EXEC && cnt < 50);
    check("reached exec", 32'(m_phase), 32'(PH_EXEC));
    #2 rst_n = 1'b0;
    #1 check("mid-exec rst req", {31'b0, imem_req}, 32'd0);
    check("mid-exec rst halted", {31'b0, halted}, 32'd0);
    check("mid-exec rst addr", 32'(imem_addr), 32'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("mid-exec rst r%0d", i), 32'(dut.r_regs[i]), 32'd0);
    @(negedge clk);
`ifdef NGP_CORE_DBG_EN
    check("no retire in reset", {31'b0, retire_valid}, 32'd0);
`endif
    #2 rst_n = 1'b1;
    wait_idle(400, "after reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
